// File: rtl/matbi_clock_pkg.sv
// Shared state encoding, field limits and default widths for the time keeper.
package matbi_clock_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOAD} state_t;

  localparam int C_SEC_MAX  = 59;
  localparam int C_MIN_MAX  = 59;
  localparam int C_HOUR_MAX = 23;

  localparam int C_SEC_BIT  = 6;
  localparam int C_MIN_BIT  = 6;
  localparam int C_HOUR_BIT = 5;
endpackage

// File: rtl/matbi_mod_counter.sv
// Modulo-(P_MAX+1) counter with synchronous load; o_carry flags the wrap on an increment.
module matbi_mod_counter #(
  parameter int P_W   = 6,
  parameter int P_MAX = 59
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_inc,
  input  logic           i_load,
  input  logic [P_W-1:0] i_load_val,
  output logic [P_W-1:0] o_value,
  output logic           o_carry
);
  logic [P_W-1:0] r_val;
  logic           w_at_max;

  assign w_at_max = (r_val == P_W'(P_MAX));
  assign o_carry  = i_inc & w_at_max;
  assign o_value  = r_val;

  always_ff @(posedge clk) begin
    if (!reset)      r_val <= '0;
    else if (i_load) r_val <= i_load_val;
    else if (i_inc)  r_val <= w_at_max ? '0 : r_val + 1'b1;
  end
endmodule

// File: rtl/matbi_time_keeper.sv
// HH:MM:SS time keeper: counts one-second ticks in RUN, accepts range-checked
// time-set requests through a one-cycle LOAD state.
module matbi_time_keeper
  import matbi_clock_pkg::*;
#(
  parameter int P_SEC_BIT  = C_SEC_BIT,
  parameter int P_MIN_BIT  = C_MIN_BIT,
  parameter int P_HOUR_BIT = C_HOUR_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run_en,
  input  logic                  i_tick,
  input  logic                  i_set_valid,
  output logic                  o_set_ready,
  input  logic [P_SEC_BIT-1:0]  i_set_sec,
  input  logic [P_MIN_BIT-1:0]  i_set_min,
  input  logic [P_HOUR_BIT-1:0] i_set_hour,
  output logic [P_SEC_BIT-1:0]  o_sec,
  output logic [P_MIN_BIT-1:0]  o_minute,
  output logic [P_HOUR_BIT-1:0] o_hour,
  output logic                  o_day_tick,
  output logic                  o_set_err
);
  state_t r_state, w_next;

  logic [P_SEC_BIT-1:0]  r_stg_sec;
  logic [P_MIN_BIT-1:0]  r_stg_min;
  logic [P_HOUR_BIT-1:0] r_stg_hour;
  logic r_set_ready, r_day_tick, r_set_err;
  logic w_hs, w_cnt, w_in_range, w_load;
  logic w_sec_c, w_min_c, w_hour_c;

  assign w_hs  = i_set_valid & r_set_ready;
  // A set request wins over a tick arriving in the same cycle.
  assign w_cnt = (r_state == ST_RUN) & i_tick & ~w_hs;

  // Zero-extend to 32 bits so the check sees the full field width.
  assign w_in_range = (32'(r_stg_sec)  <= 32'(C_SEC_MAX)) &
                      (32'(r_stg_min)  <= 32'(C_MIN_MAX)) &
                      (32'(r_stg_hour) <= 32'(C_HOUR_MAX));
  assign w_load     = (r_state == ST_LOAD) & w_in_range;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_next = ST_LOAD; else if (i_run_en)  w_next = ST_RUN;
      ST_RUN:  if (w_hs) w_next = ST_LOAD; else if (!i_run_en) w_next = ST_IDLE;
      ST_LOAD: w_next = i_run_en ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stg_sec   <= '0;
      r_stg_min   <= '0;
      r_stg_hour  <= '0;
      r_set_ready <= 1'b0;
      r_day_tick  <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_stg_sec  <= i_set_sec;
        r_stg_min  <= i_set_min;
        r_stg_hour <= i_set_hour;
      end
      r_set_ready <= (w_next != ST_LOAD);
      r_day_tick  <= w_hour_c;
      r_set_err   <= (r_state == ST_LOAD) & ~w_in_range;
    end
  end

  matbi_mod_counter #(.P_W(P_SEC_BIT), .P_MAX(C_SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .i_inc(w_cnt), .i_load(w_load),
    .i_load_val(r_stg_sec), .o_value(o_sec), .o_carry(w_sec_c));

  matbi_mod_counter #(.P_W(P_MIN_BIT), .P_MAX(C_MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .i_inc(w_sec_c), .i_load(w_load),
    .i_load_val(r_stg_min), .o_value(o_minute), .o_carry(w_min_c));

  matbi_mod_counter #(.P_W(P_HOUR_BIT), .P_MAX(C_HOUR_MAX)) u_hour (
    .clk(clk), .reset(reset), .i_inc(w_min_c), .i_load(w_load),
    .i_load_val(r_stg_hour), .o_value(o_hour), .o_carry(w_hour_c));

  assign o_set_ready = r_set_ready;
  assign o_day_tick  = r_day_tick;
  assign o_set_err   = r_set_err;
endmodule

// File: tb/tb_matbi_time_keeper.sv
// Randomized and directed checks of matbi_time_keeper against a seconds-of-day model.
module tb_matbi_time_keeper;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_run_en = 1'b0, i_tick = 1'b0, i_set_valid = 1'b0;
  logic [5:0] i_set_sec = '0, i_set_min = '0;
  logic [4:0] i_set_hour = '0;
  logic       o_set_ready, o_day_tick, o_set_err;
  logic [5:0] o_sec, o_minute;
  logic [4:0] o_hour;

  matbi_time_keeper dut (
    .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_tick(i_tick),
    .i_set_valid(i_set_valid), .o_set_ready(o_set_ready),
    .i_set_sec(i_set_sec), .i_set_min(i_set_min), .i_set_hour(i_set_hour),
    .o_sec(o_sec), .o_minute(o_minute), .o_hour(o_hour),
    .o_day_tick(o_day_tick), .o_set_err(o_set_err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: time of day as seconds since midnight plus a pending-load flag.
  int m_t = 0, m_ss = 0, m_sm = 0, m_sh = 0;
  bit m_ready = 0, m_run = 0, m_load = 0, m_day = 0, m_err = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_t <= 0; m_ready <= 0; m_run <= 0; m_load <= 0;
      m_day <= 0; m_err <= 0; m_ss <= 0; m_sm <= 0; m_sh <= 0;
    end else begin
      m_day <= 0; m_err <= 0;
      if (m_load) begin
        if (m_ss < 60 && m_sm < 60 && m_sh < 24) m_t <= m_sh * 3600 + m_sm * 60 + m_ss;
        else m_err <= 1;
        m_load <= 0; m_run <= i_run_en; m_ready <= 1;
      end else if (i_set_valid && m_ready) begin
        m_ss <= int'(i_set_sec); m_sm <= int'(i_set_min); m_sh <= int'(i_set_hour);
        m_load <= 1; m_ready <= 0;
      end else begin
        if (m_run && i_tick) begin
          m_t   <= (m_t + 1) % 86400;
          m_day <= (m_t == 86399);
        end
        m_run <= i_run_en; m_ready <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sec",   int'(o_sec),    m_t % 60);
      check("min",   int'(o_minute), (m_t / 60) % 60);
      check("hour",  int'(o_hour),   m_t / 3600);
      check("ready", int'(o_set_ready), int'(m_ready));
      check("day",   int'(o_day_tick),  int'(m_day));
      check("err",   int'(o_set_err),   int'(m_err));
    end
  end

  task automatic step(); @(negedge clk); endtask

  // Literal pin on both the DUT and the model.
  task automatic lit_time(input string nm, input int h, input int m, input int s);
    check({nm, "_h"}, int'(o_hour), h);
    check({nm, "_m"}, int'(o_minute), m);
    check({nm, "_s"}, int'(o_sec), s);
    check({nm, "_model"}, m_t, h * 3600 + m * 60 + s);
  endtask

  task automatic set_req(input int h, input int m, input int s);
    i_set_valid = 1; i_set_hour = 5'(h); i_set_min = 6'(m); i_set_sec = 6'(s);
    step();
    i_set_valid = 0;
    i_set_hour = 5'($urandom); i_set_min = 6'($urandom); i_set_sec = 6'($urandom);
  endtask

  initial begin
    step(); chk_en = 1;
    // Reset held 3 cycles
    repeat (3) step();
    check("rst_ready", int'(o_set_ready), 0);
    lit_time("rst", 0, 0, 0);
    reset = 1; step();
    check("rel_ready", int'(o_set_ready), 1);
    lit_time("rel", 0, 0, 0);

    // Set 12:34:56 in IDLE then 4 ticks
    set_req(12, 34, 56);
    check("load_ready", int'(o_set_ready), 0);
    step();
    lit_time("set1", 12, 34, 56);
    i_run_en = 1; step();
    i_tick = 1;
    step(); lit_time("t1", 12, 34, 57);
    step(); lit_time("t2", 12, 34, 58);
    step(); lit_time("t3", 12, 34, 59);
    step(); lit_time("t4", 12, 35, 0);
    i_tick = 0;

    // Day rollover
    set_req(23, 59, 59); step(); step();
    lit_time("set2", 23, 59, 59);
    i_tick = 1; step(); i_tick = 0;
    lit_time("roll", 0, 0, 0);
    check("day_hi", int'(o_day_tick), 1);
    step();
    check("day_lo", int'(o_day_tick), 0);

    // Out-of-range minute
    set_req(10, 60, 0);
    check("bad_ready0", int'(o_set_ready), 0);
    step();
    check("bad_err", int'(o_set_err), 1);
    check("bad_ready1", int'(o_set_ready), 1);
    lit_time("bad", 0, 0, 0);
    step();
    check("bad_err_lo", int'(o_set_err), 0);

    // Set with simultaneous tick, then tick during LOAD
    i_tick = 1; set_req(1, 2, 3);
    step(); i_tick = 0;
    lit_time("prio", 1, 2, 3);

    // Reset during LOAD
    set_req(5, 5, 5);
    reset = 0; step(); reset = 1;
    lit_time("rstload", 0, 0, 0);
    check("rstload_err", int'(o_set_err), 0);
    i_run_en = 0; i_tick = 1; step(); i_tick = 0;
    lit_time("idle_tick", 0, 0, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      i_run_en    = ($urandom_range(0, 9) != 0);
      i_tick      = ($urandom_range(0, 1) == 1);
      i_set_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin
        i_set_hour = 5'($urandom); i_set_min = 6'($urandom); i_set_sec = 6'($urandom);
      end else begin
        i_set_hour = 5'($urandom_range(0, 23));
        i_set_min  = 6'($urandom_range(0, 59));
        i_set_sec  = 6'($urandom_range(0, 59));
        if ($urandom_range(0, 3) == 0) begin
          i_set_hour = 5'd23; i_set_min = 6'd59; i_set_sec = 6'($urandom_range(55, 59));
        end
      end
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1; i_set_valid = 0; i_tick = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matbi_time_keeper.md
MATBI_TIME_KEEPER -- requirements
Module: matbi_time_keeper

Interface
REQ-001 Parameter P_SEC_BIT, default 6, sets the seconds field width.
REQ-002 Parameter P_MIN_BIT, default 6, sets the minutes field width.
REQ-003 Parameter P_HOUR_BIT, default 5, sets the hours field width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 i_run_en  input  1  counting enable.
REQ-007 i_tick  input  1  one-cycle one-second tick from the tick generator.
REQ-008 i_set_valid  input  1  time-set request, valid/ready handshake.
REQ-009 o_set_ready  output  1  the block can accept a time-set request.
REQ-010 i_set_sec / i_set_min / i_set_hour  input  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  requested time.
REQ-011 o_sec / o_minute / o_hour  output  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  current time, registered.
REQ-012 o_day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-013 o_set_err  output  1  one-cycle pulse when a time-set request is out of range.

Function
REQ-014 The FSM shall have three states: IDLE, RUN and LOAD.
REQ-015 FSM transitions:
- IDLE -> RUN when i_run_en=1.
- RUN -> IDLE when i_run_en=0.
- IDLE/RUN -> LOAD on a handshake (i_set_valid & o_set_ready).
- LOAD -> RUN when i_run_en=1, otherwise LOAD -> IDLE; LOAD always lasts exactly 1 cycle.
REQ-016 o_set_ready shall be a registered output: 1 in IDLE/RUN, 0 in LOAD.
REQ-017 On a handshake, i_set_sec, i_set_min and i_set_hour shall be captured into staging registers; the input values in later cycles are ignored.
REQ-018 In LOAD, range check: sec<60, min<60, hour<24.
- Pass: load the staged time.
- Fail: keep the current time and pulse o_set_err in the following cycle.
REQ-019 Load latency: handshake in cycle N -> new time visible on the outputs in cycle N+2; o_set_ready is back to 1 in cycle N+2.
REQ-020 Counting shall occur only when state=RUN, i_tick=1, and no handshake occurs in that same cycle.
REQ-021 Counting order per counted tick:
- sec increments; 59 wraps to 0 with a carry to minute.
- minute wraps 59 -> 0 with a carry to hour.
- hour wraps 23 -> 0 with o_day_tick=1.
- All three fields update in the same cycle.
REQ-022 Output latency: tick in cycle N -> updated time and o_day_tick in cycle N+1; o_day_tick is high for exactly 1 cycle.
REQ-023 Ticks in IDLE, in LOAD, or in a handshake cycle shall be dropped: no count, no queuing.
REQ-024 A set request shall take priority over a simultaneous tick.
REQ-025 Arithmetic:
- Comparisons use the full field width.
- Counters never exceed 59/59/23 in operation.
- Inputs outside this range are rejected, never truncated.

Reset
REQ-026 While reset=0 at a clk edge:
- state = IDLE.
- o_sec, o_minute, o_hour = 0.
- o_day_tick = 0, o_set_err = 0, o_set_ready = 0.
- staging registers = 0.
REQ-027 o_set_ready shall rise in the first cycle after reset is released.
REQ-028 A reset during LOAD shall abort the load: the time goes to 00:00:00 and the staged values are discarded.

Structure
REQ-029 The shared package matbi_clock_pkg shall hold:
- the state encoding (IDLE, RUN, LOAD);
- constants C_SEC_MAX=59, C_MIN_MAX=59, C_HOUR_MAX=23;
- the default field widths.
REQ-030 Sub-module matbi_mod_counter (parameters: width, max value; ports: inc, load, load value, value, carry) shall be instantiated three times and chained by carry.

Verification
REQ-031 Reset held 3 cycles, release, run_en=0 -> outputs 00:00:00; o_set_ready=1 in the first cycle after release.
REQ-032 Set 12:34:56 in IDLE, then run_en=1 and 4 ticks -> 12:35:00; each update 1 cycle after its tick.
REQ-033 Set 23:59:59, RUN, 1 tick -> next cycle 00:00:00 with o_day_tick=1 for 1 cycle only.
REQ-034 Set 10:60:00 -> o_set_err pulses once, time unchanged, o_set_ready=0 for exactly 1 cycle.
REQ-035 In RUN, i_set_valid and i_tick in the same cycle (set 01:02:03) -> tick dropped, output 01:02:03 at N+2; a tick during LOAD is also dropped.
REQ-036 Reset asserted in the LOAD cycle of a set 05:05:05 -> output 00:00:00, state IDLE, no o_set_err.
